// File: rtl/cpu_step_ctrl_if.sv
// Signal bundle between the run/step controller and its CPU/board environment.
// Names carry the controller's direction: _i into cpu_step_ctrl, _o out of it.
interface cpu_step_ctrl_if;
  logic        run_sw_i;
  logic        step_key_ni;
  logic        bp_en_i;
  logic [31:0] bp_addr_i;
  logic [31:0] pc_i;
  logic        cpu_en_o;
  logic [1:0]  state_o;
  logic        halted_o;
  logic [31:0] instr_cnt_o;

  modport master (
    input  run_sw_i, step_key_ni, bp_en_i, bp_addr_i, pc_i,
    output cpu_en_o, state_o, halted_o, instr_cnt_o
  );

  modport slave (
    output run_sw_i, step_key_ni, bp_en_i, bp_addr_i, pc_i,
    input  cpu_en_o, state_o, halted_o, instr_cnt_o
  );
endinterface

// File: rtl/cpu_step_ctrl.sv
// Run/single-step execution controller for a single-cycle CPU, paced by a divided tick.
// Define BREAKPOINT_EN to add the PC breakpoint comparator and the BREAK state.
//
// state | meaning
// HALT  | stopped, waiting for run switch or a step press
// RUN   | one execute pulse per tick while the run switch is on
// STEP  | one execute pulse on the next tick, then back to HALT
// BREAK | stopped on a breakpoint hit; press steps over it, switch off halts
module cpu_step_ctrl #(
  parameter int unsigned DIV_MAX      = 50_000_000,
  parameter int unsigned DEBOUNCE_CYC = 500_000
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  cpu_step_ctrl_if.master  bus
);

  localparam int unsigned DIV_W = (DIV_MAX > 1) ? $clog2(DIV_MAX) : 1;
  localparam int unsigned DEB_W = $clog2(DEBOUNCE_CYC + 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV_MAX - 1);
  localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEBOUNCE_CYC - 1);
  localparam logic [DEB_W-1:0] DEB_SAT  = DEB_W'(DEBOUNCE_CYC);

  localparam logic [1:0] S_HALT  = 2'b00;
  localparam logic [1:0] S_RUN   = 2'b01;
  localparam logic [1:0] S_STEP  = 2'b10;
  localparam logic [1:0] S_BREAK = 2'b11;

  logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
  logic [1:0]       run_sync_q, key_sync_q;
  logic [DEB_W-1:0] deb_cnt_q, deb_cnt_d;
  logic             press_q, press_d;
  logic [1:0]       state_q, state_d;
  logic             cpu_en_q, cpu_en_d;
  logic [31:0]      instr_cnt_q, instr_cnt_d;
  logic             tick, run_sw, key_n, bp_hit;

  assign tick   = (div_cnt_q == DIV_LAST);
  assign run_sw = run_sync_q[1];
  assign key_n  = key_sync_q[1];

`ifdef BREAKPOINT_EN
  assign bp_hit = bus.bp_en_i && (bus.pc_i == bus.bp_addr_i);
`else
  logic unused_bp;
  assign unused_bp = &{1'b0, bus.bp_en_i, bus.bp_addr_i, bus.pc_i};
  assign bp_hit    = 1'b0;
`endif

  assign div_cnt_d   = tick ? '0 : div_cnt_q + DIV_W'(1);
  assign instr_cnt_d = cpu_en_q ? instr_cnt_q + 32'd1 : instr_cnt_q;

  // Count saturates at DEBOUNCE_CYC so a held key yields a single press.
  always_comb begin
    deb_cnt_d = deb_cnt_q;
    press_d   = 1'b0;
    if (key_n) begin
      deb_cnt_d = '0;
    end else if (deb_cnt_q != DEB_SAT) begin
      deb_cnt_d = deb_cnt_q + DEB_W'(1);
      press_d   = (deb_cnt_q == DEB_LAST);
    end
  end

  always_comb begin
    state_d  = state_q;
    cpu_en_d = 1'b0;
    case (state_q)
      S_HALT: begin
        if (run_sw)       state_d = S_RUN;
        else if (press_q) state_d = S_STEP;
      end
      S_RUN: begin
        // Switch-off wins over a coincident tick.
        if (!run_sw) begin
          state_d = S_HALT;
        end else if (tick) begin
          if (bp_hit) state_d  = S_BREAK;
          else        cpu_en_d = 1'b1;
        end
      end
      S_STEP: begin
        if (tick) begin
          cpu_en_d = 1'b1;
          state_d  = S_HALT;
        end
      end
      S_BREAK: begin
        if (press_q)      state_d = S_STEP;
        else if (!run_sw) state_d = S_HALT;
      end
      default: state_d = S_HALT;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      div_cnt_q   <= '0;
      run_sync_q  <= 2'b11;
      key_sync_q  <= 2'b11;
      deb_cnt_q   <= '0;
      press_q     <= 1'b0;
      state_q     <= S_HALT;
      cpu_en_q    <= 1'b0;
      instr_cnt_q <= '0;
    end else begin
      div_cnt_q   <= div_cnt_d;
      run_sync_q  <= {run_sync_q[0], bus.run_sw_i};
      key_sync_q  <= {key_sync_q[0], bus.step_key_ni};
      deb_cnt_q   <= deb_cnt_d;
      press_q     <= press_d;
      state_q     <= state_d;
      cpu_en_q    <= cpu_en_d;
      instr_cnt_q <= instr_cnt_d;
    end
  end

  assign bus.cpu_en_o    = cpu_en_q;
  assign bus.state_o     = state_q;
  assign bus.halted_o    = (state_q == S_HALT) || (state_q == S_BREAK);
  assign bus.instr_cnt_o = instr_cnt_q;

endmodule

// File: tb/tb_cpu_step_ctrl.sv
// Directed bench for cpu_step_ctrl with DIV_MAX=4, DEBOUNCE_CYC=3.
// Edge k after reset release leaves the tick counter at k mod 4; ticks fire on edges k mod 4 == 0.
module tb_cpu_step_ctrl;
  logic clk_i = 1'b0;
  logic rst_ni;
  int   n_checks = 0;
  int   n_fail   = 0;

  cpu_step_ctrl_if bus ();

  cpu_step_ctrl #(.DIV_MAX(4), .DEBOUNCE_CYC(3)) dut (
    .clk_i (clk_i),
    .rst_ni(rst_ni),
    .bus   (bus)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic wait_en(input int max_cyc, output bit found);
    found = 1'b0;
    for (int i = 0; i < max_cyc && !found; i++) begin
      @(negedge clk_i);
      if (bus.cpu_en_o === 1'b1) found = 1'b1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected end of test");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit found;
    int pulses;
    bit seen_step;
    bit seen_break;
    logic [31:0] exp_cnt;

    rst_ni          = 1'b0;
    bus.run_sw_i    = 1'b1;
    bus.step_key_ni = 1'b1;
    bus.bp_en_i     = 1'b0;
    bus.bp_addr_i   = 32'h10;
    bus.pc_i        = 32'h0;
    repeat (3) @(negedge clk_i);
    chk("rst_state",  32'(bus.state_o),  32'd0);
    chk("rst_halted", 32'(bus.halted_o), 32'd1);
    chk("rst_en",     32'(bus.cpu_en_o), 32'd0);
    chk("rst_cnt",    bus.instr_cnt_o,   32'd0);

    // Free run: pulses on c = 4, 8, 12, 16, 20
    rst_ni = 1'b1;
    for (int c = 1; c <= 21; c++) begin
      @(negedge clk_i);
      chk($sformatf("run_en_c%0d", c), 32'(bus.cpu_en_o), 32'((c % 4) == 0));
      if (c == 1) chk("run_entered", 32'(bus.state_o), 32'd1);
    end
    chk("run_cnt5", bus.instr_cnt_o, 32'd5);

    // Switch off so the synchronized value drops exactly for the edge-24 tick
    bus.run_sw_i = 1'b0;
    @(negedge clk_i);
    chk("sw_c22_state", 32'(bus.state_o), 32'd1);
    @(negedge clk_i);
    chk("sw_c23_state", 32'(bus.state_o), 32'd1);
    @(negedge clk_i);
    chk("sw_tick_state",  32'(bus.state_o),  32'd0);
    chk("sw_tick_en",     32'(bus.cpu_en_o), 32'd0);
    chk("sw_tick_halted", 32'(bus.halted_o), 32'd1);
    chk("sw_tick_cnt",    bus.instr_cnt_o,   32'd5);

    // Short glitch on the key: no step
    bus.step_key_ni = 1'b0;
    repeat (2) @(negedge clk_i);
    bus.step_key_ni = 1'b1;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk_i);
      chk("glitch_state_en", {29'd0, bus.state_o, bus.cpu_en_o}, 32'd0);
    end

    // Long press held 10 cycles: exactly one step pulse
    pulses = 0; seen_step = 1'b0;
    bus.step_key_ni = 1'b0;
    for (int c = 0; c < 22; c++) begin
      if (c == 10) bus.step_key_ni = 1'b1;
      @(negedge clk_i);
      if (bus.cpu_en_o === 1'b1) pulses++;
      if (bus.state_o === 2'b10) seen_step = 1'b1;
    end
    chk("step_pulses", 32'(pulses),        32'd1);
    chk("step_seen",   32'(seen_step),     32'd1);
    chk("step_state",  32'(bus.state_o),   32'd0);
    chk("step_cnt",    bus.instr_cnt_o,    32'd6);

    bus.bp_en_i = 1'b1;
    bus.pc_i    = 32'h10;
`ifdef BREAKPOINT_EN
    pulses = 0; seen_break = 1'b0;
    bus.run_sw_i = 1'b1;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk_i);
      if (bus.cpu_en_o === 1'b1) pulses++;
      if (bus.state_o === 2'b11) seen_break = 1'b1;
    end
    chk("bp_break_seen", 32'(seen_break),   32'd1);
    chk("bp_state",      32'(bus.state_o),  32'd3);
    chk("bp_halted",     32'(bus.halted_o), 32'd1);
    chk("bp_no_pulse",   32'(pulses),       32'd0);
    bus.step_key_ni = 1'b0;
    repeat (5) @(negedge clk_i);
    bus.step_key_ni = 1'b1;
    wait_en(20, found);
    chk("bp_step_pulse", 32'(found),       32'd1);
    chk("bp_step_state", 32'(bus.state_o), 32'd0);
    bus.run_sw_i = 1'b0;
    repeat (8) @(negedge clk_i);
    exp_cnt = 32'd7;
`else
    pulses = 0; seen_break = 1'b0;
    bus.run_sw_i = 1'b1;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk_i);
      if (bus.cpu_en_o === 1'b1) pulses++;
      if (bus.state_o === 2'b11) seen_break = 1'b1;
    end
    chk("nobp_break_seen", 32'(seen_break), 32'd0);
    chk("nobp_pulses",     32'(pulses),     32'd3);
    bus.run_sw_i = 1'b0;
    repeat (8) @(negedge clk_i);
    exp_cnt = 32'd9;
`endif
    chk("post_bp_state", 32'(bus.state_o), 32'd0);
    chk("post_bp_cnt",   bus.instr_cnt_o,  exp_cnt);
    bus.bp_en_i = 1'b0;

    // Counter wrap
    force dut.instr_cnt_q = 32'hFFFF_FFFF;
    @(negedge clk_i);
    release dut.instr_cnt_q;
    @(negedge clk_i);
    chk("wrap_preload", bus.instr_cnt_o, 32'hFFFF_FFFF);
    bus.step_key_ni = 1'b0;
    repeat (5) @(negedge clk_i);
    bus.step_key_ni = 1'b1;
    wait_en(20, found);
    chk("wrap_pulse", 32'(found), 32'd1);
    @(negedge clk_i);
    chk("wrap_cnt",   bus.instr_cnt_o,  32'd0);
    chk("wrap_state", 32'(bus.state_o), 32'd0);

    // Reset in the middle of a pulse
    bus.run_sw_i = 1'b1;
    wait_en(20, found);
    chk("mid_pulse_seen", 32'(found), 32'd1);
    rst_ni = 1'b0;
    #1;
    chk("mid_rst_en",     32'(bus.cpu_en_o), 32'd0);
    chk("mid_rst_state",  32'(bus.state_o),  32'd0);
    chk("mid_rst_cnt",    bus.instr_cnt_o,   32'd0);
    chk("mid_rst_halted", 32'(bus.halted_o), 32'd1);
    @(negedge clk_i);
    rst_ni = 1'b1;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk_i);
      chk($sformatf("post_rst_en_c%0d", c), 32'(bus.cpu_en_o), 32'(c == 4));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
